// File: rtl/psram_qspi_target.sv
`default_nettype none
// ============================================================================
// Module   : psram_qspi_target
// Brief    : APS6404-style 4-bit QSPI/QPI PSRAM responder backed by on-chip
//            RAM. Oversamples sclk/cs/data with clk and services SPI/QPI
//            mode switching, reset-enable/reset, quad read (0xEB) and quad
//            write (0x38).
// Revision : 1.0 - initial release
// ============================================================================
module psram_qspi_target #(
  parameter int         ADDR_BITS   = 10,
  parameter int         WAIT_CYCLES = 6,
  parameter logic [7:0] INIT_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_psram_cs,
  input  logic       i_psram_sclk,
  input  logic [3:0] i_psram_data,
  output logic [3:0] o_psram_data,
  output logic       o_psram_oe,
  output logic       o_qpi_mode,
  output logic [7:0] o_last_cmd,
  output logic       o_cmd_err
);

  localparam int c_depth  = 1 << ADDR_BITS;
  localparam int c_wait_w = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [c_wait_w-1:0]  c_wait_last = c_wait_w'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [c_wait_w-1:0]  c_wait_one  = c_wait_w'(1);
  localparam logic [ADDR_BITS-1:0] c_addr_one  = ADDR_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ADDR    = 3'd2,
    S_WAIT    = 3'd3,
    S_RD_DATA = 3'd4,
    S_WR_DATA = 3'd5,
    S_IGNORE  = 3'd6
  } state_t;

  state_t                r_state;
  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;
  logic [2:0]            r_cs_sync;    // [0] stage 1, [1] stage 2, [2] history
  logic [2:0]            r_sclk_sync;
  logic [3:0]            r_dat_s1;
  logic [3:0]            r_dat_s2;
  logic                  w_cs_rise;
  logic                  w_cs_fall;
  logic                  w_sclk_rise;
  logic                  w_sclk_fall;
  logic [6:0]            r_cmd_sr;
  logic [7:0]            w_cmd_next;
  logic                  w_cmd_done;
  logic [2:0]            r_cnt;
  logic [c_wait_w-1:0]   r_wait_cnt;
  logic                  r_phase;      // 0: high nibble next, 1: low nibble next
  logic [3:0]            r_wr_hi;
  logic                  r_rst_en;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [ADDR_BITS+3:0]  w_addr_shift;
  logic [3:0]            w_unused_addr_hi;
  logic                  w_we;
  logic [7:0]            r_rd_byte;

  // Backing store; contents set at configuration and never cleared by reset
  logic [7:0] r_mem [c_depth] = '{default: INIT_BYTE};

  // Reset synchronizer: asynchronous assertion, synchronous release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Two-flop synchronizers plus one history stage for edge detection
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cs_sync   <= 3'b111;
      r_sclk_sync <= 3'b000;
      r_dat_s1    <= 4'h0;
      r_dat_s2    <= 4'h0;
    end else begin
      r_cs_sync   <= {r_cs_sync[1:0], i_psram_cs};
      r_sclk_sync <= {r_sclk_sync[1:0], i_psram_sclk};
      r_dat_s1    <= i_psram_data;
      r_dat_s2    <= r_dat_s1;
    end
  end

  assign w_cs_rise   =  r_cs_sync[1]   & ~r_cs_sync[2];
  assign w_cs_fall   = ~r_cs_sync[1]   &  r_cs_sync[2];
  assign w_sclk_rise =  r_sclk_sync[1] & ~r_sclk_sync[2] & ~r_cs_sync[1];
  assign w_sclk_fall = ~r_sclk_sync[1] &  r_sclk_sync[2] & ~r_cs_sync[1];

  // Command byte including the bit/nibble arriving on this rise
  assign w_cmd_next = o_qpi_mode ? {r_cmd_sr[3:0], r_dat_s2} : {r_cmd_sr, r_dat_s2[0]};
  assign w_cmd_done = o_qpi_mode ? (r_cnt == 3'd1) : (r_cnt == 3'd7);

  // Only the low ADDR_BITS of the 24-bit bus address are kept
  assign w_addr_shift     = {r_addr, r_dat_s2};
  assign w_unused_addr_hi = w_addr_shift[ADDR_BITS+3:ADDR_BITS];

  assign w_we = (r_state == S_WR_DATA) && w_sclk_rise && r_phase;

  // Memory write port and a synchronous read that keeps the prefetch register
  // following the current burst address
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_addr] <= {r_wr_hi, r_dat_s2};
    r_rd_byte <= r_mem[r_addr];
  end

  // Protocol FSM with registered outputs
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= S_IDLE;
      o_psram_oe   <= 1'b0;
      o_psram_data <= 4'h0;
      o_qpi_mode   <= 1'b0;
      o_last_cmd   <= 8'h00;
      o_cmd_err    <= 1'b0;
      r_cmd_sr     <= 7'h00;
      r_cnt        <= 3'd0;
      r_wait_cnt   <= '0;
      r_phase      <= 1'b0;
      r_wr_hi      <= 4'h0;
      r_rst_en     <= 1'b0;
      r_addr       <= '0;
    end else begin
      o_cmd_err <= 1'b0;
      if (w_cs_rise) begin
        r_state    <= S_IDLE;
        o_psram_oe <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cs_fall) begin
              r_state <= S_CMD;
              r_cnt   <= 3'd0;
            end
          end
          S_CMD: begin
            if (w_sclk_rise) begin
              r_cmd_sr <= w_cmd_next[6:0];
              r_cnt    <= r_cnt + 3'd1;
              if (w_cmd_done) begin
                o_last_cmd <= w_cmd_next;
                r_rst_en   <= 1'b0;
                r_cnt      <= 3'd0;
                r_state    <= S_IGNORE;
                if (!o_qpi_mode && w_cmd_next == 8'h35) begin
                  o_qpi_mode <= 1'b1;
                end else if (o_qpi_mode && w_cmd_next == 8'hF5) begin
                  o_qpi_mode <= 1'b0;
                end else if (w_cmd_next == 8'h66) begin
                  r_rst_en <= 1'b1;
                end else if (w_cmd_next == 8'h99) begin
                  // Reset without a preceding reset-enable is silently dropped
                  if (r_rst_en) o_qpi_mode <= 1'b0;
                end else if (o_qpi_mode && (w_cmd_next == 8'hEB || w_cmd_next == 8'h38)) begin
                  r_state <= S_ADDR;
                end else begin
                  o_cmd_err <= 1'b1;
                end
              end
            end
          end
          S_ADDR: begin
            if (w_sclk_rise) begin
              r_addr <= w_addr_shift[ADDR_BITS-1:0];
              r_cnt  <= r_cnt + 3'd1;
              if (r_cnt == 3'd5) begin
                r_cnt      <= 3'd0;
                r_phase    <= 1'b0;
                r_wait_cnt <= '0;
                if (o_last_cmd == 8'h38)  r_state <= S_WR_DATA;
                else if (WAIT_CYCLES == 0) r_state <= S_RD_DATA;
                else                       r_state <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (w_sclk_rise) begin
              if (r_wait_cnt == c_wait_last) r_state <= S_RD_DATA;
              else                           r_wait_cnt <= r_wait_cnt + c_wait_one;
            end
          end
          S_RD_DATA: begin
            if (w_sclk_fall) begin
              o_psram_oe <= 1'b1;
              if (!r_phase) begin
                o_psram_data <= r_rd_byte[7:4];
                r_phase      <= 1'b1;
              end else begin
                o_psram_data <= r_rd_byte[3:0];
                r_addr       <= r_addr + c_addr_one;
                r_phase      <= 1'b0;
              end
            end
          end
          S_WR_DATA: begin
            if (w_sclk_rise) begin
              if (!r_phase) begin
                r_wr_hi <= r_dat_s2;
                r_phase <= 1'b1;
              end else begin
                r_addr  <= r_addr + c_addr_one;
                r_phase <= 1'b0;
              end
            end
          end
          S_IGNORE: begin
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/psram_qspi_target.md
Name: psram_qspi_target

Overview:
- Synthesizable responder for the PSRAM side of the memory controller's QSPI/QPI bus. It emulates one APS6404-style 4-bit PSRAM die backed by on-chip RAM.
- Used in benches and in RAM-less bring-up builds in place of the external chip. Two instances, one per nibble lane, cover the 8-bit psram data bus.
- Oversamples psram sclk/cs/data with the system clock and decodes SPI/QPI commands. Services quad reads and writes, and drives read data with a separate output enable.

Parameters:
- ADDR_BITS, 10: backing-store address width (1 KiB); the 24-bit bus address is used modulo 2^ADDR_BITS.
- WAIT_CYCLES, 6: sclk cycles between the last address nibble and the first read-data nibble (0xEB).
- INIT_BYTE, 8'h00: value every memory byte holds after configuration (not re-cleared by reset).

Ports:
- clk, input, 1: system clock; must be at least 4x the psram sclk frequency.
- reset, input, 1: asynchronous, active-low reset.
- i_psram_cs, input, 1: chip select from memory controller, active-low.
- i_psram_sclk, input, 1: serial clock from memory controller.
- i_psram_data, input, 4: sampled data lane (SIO[3:0]).
- o_psram_data, output, 4: read data nibble.
- o_psram_oe, output, 1: 1 = target drives the lane.
- o_qpi_mode, output, 1: 1 = device in QPI mode.
- o_last_cmd, output, 8: last fully received command byte.
- o_cmd_err, output, 1: one-clk pulse when an unsupported command is decoded.

Behaviour:
- Reset (async assert, sync release): state IDLE, o_psram_oe=0, o_psram_data=0, o_qpi_mode=0, o_last_cmd=0, o_cmd_err=0. Memory contents are untouched.
- Inputs pass 2-FF synchronizers plus one history stage. An sclk rise/fall event is a synced edge with synced cs=0. Data is sampled at the synced rise.
- Any synced cs rise forces IDLE and o_psram_oe=0 on the next clk, from any state. A partially received byte is discarded, and a partial command or address has no effect.
- Command, SPI mode: 8 bits on data[0], MSB first, one per sclk rise.
- Command, QPI mode: 2 nibbles, high first.
- Addresses are always 6 nibbles, high first, in QPI. In SPI mode only 0x35, 0x66 and 0x99 are decoded; everything else is unsupported.
- States:
  - IDLE: cs fall -> CMD.
  - CMD: command complete -> load o_last_cmd, then decode:
    - 0x35 (SPI) -> qpi=1, go to IGNORE.
    - 0xF5 (QPI) -> qpi=0, go to IGNORE.
    - 0x66 -> arm the reset-enable flag, go to IGNORE.
    - 0x99 with the flag armed -> qpi=0, go to IGNORE.
    - 0xEB or 0x38 (QPI) -> ADDR.
    - Anything else -> o_cmd_err pulse, go to IGNORE.
    - The reset-enable flag clears on any command other than 0x66.
  - ADDR: 6 rises -> 0x38 goes to WR_DATA; 0xEB goes to WAIT, where a memory read of the address is issued.
  - WAIT: count WAIT_CYCLES sclk rises. The prefetched byte must be ready before the last one.
  - RD_DATA: each sclk fall -> drive the next nibble, oe=1. The first nibble is the high nibble of byte[addr] and is driven at the fall after the last wait rise. After a low nibble, addr increments and the next byte is prefetched within 2 clk.
  - WR_DATA: each pair of rises (high nibble, then low) -> write byte to addr, then increment addr.
  - IGNORE: wait for cs high.
- Address increment wraps from 2^ADDR_BITS-1 to 0, with no page boundary.
- Upper address bits are ignored, not flagged.
- Bursts are unbounded; the controller's cs deassertion ends them.
- A write and a prefetch never occur in the same transaction, so there is no read/write collision.
- sclk edges while cs is high are ignored. A cs fall while busy cannot occur without a rise first.
- Reset mid-transaction: oe drops immediately (async). Bytes written before the reset remain in memory.

Test Plan:
- Reset then idle -> o_qpi_mode=0, o_psram_oe=0, o_last_cmd=00, no o_cmd_err.
- SPI 0x35, then cs high -> o_qpi_mode=1, o_last_cmd=35. QPI 0xF5 -> o_qpi_mode=0.
- QPI 0x38, addr 000001, data FF; then 0xEB, addr 000001, 6 wait clocks, 4 sclk falls -> nibbles F,F then INIT_BYTE nibbles (0,0). oe=1 only during data.
- Burst write 0x38 at addr 3FF with bytes A5,5A, then read from 3FF -> A5,5A; byte 000 is 5A (wrap).
- Write A5 to addr 010, then 0x38 at addr 010 with only a high nibble 3 before cs rises -> addr 010 is unchanged (still A5). A subsequent command decodes correctly.
- QPI unknown command 12 -> one-clk o_cmd_err, o_last_cmd=12, no oe. 0x99 without a preceding 0x66 leaves qpi=1. 0x66 then 0x99 sets qpi=0. Reset asserted mid-read -> oe=0 the same cycle.
